// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the byte-serial arithmetic blocks.
//   - BYTE_W  : width of one serial digit (one byte).
//   - state_t : frame-position FSM states used by serial ALU tops.
//   - sub_ovf : two's-complement overflow rule for a subtraction, evaluated on
//               the most-significant bits of minuend, subtrahend and result.
package alu_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    S_FIRST = 1'b0,
    S_BODY  = 1'b1
  } state_t;

  // Signed a - b overflows only when the operands differ in sign and the
  // result's sign differs from the minuend's.
  function automatic logic sub_ovf(input logic a_msb,
                                   input logic b_msb,
                                   input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/sub8b_slice.sv
// sub8b_slice
//   Combinational BYTE_W-bit carry-lookahead adder: sum = a + b + cin.
//   Used as the datapath of a serial subtractor; the caller supplies the
//   already-inverted subtrahend on b.
// Ports:
//   a    [BYTE_W-1:0] in   first addend
//   b    [BYTE_W-1:0] in   second addend (caller applies ~subtrahend)
//   cin               in   carry into bit 0
//   sum  [BYTE_W-1:0] out  sum bits
//   cout              out  carry out of the top bit
module sub8b_slice
  import alu_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;
  logic              pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded directly from generate/propagate terms and cin,
  // so no carry depends on a lower carry (flat lookahead, not a ripple).
  //   c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
  always_comb begin
    c    = '0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < BYTE_W; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
  end

  assign sum  = p ^ c[BYTE_W-1:0];
  assign cout = c[BYTE_W];

endmodule

// File: rtl/sub8b_serial.sv
// sub8b_serial
//   Byte-serial multi-byte subtractor (a - b), least-significant byte first,
//   with valid/ready handshakes on both sides and a one-entry output register.
//   Each byte is computed as a + ~b + carry, carry = 1 on the first byte of a
//   frame. Frames longer than MAX_BYTES are cut at MAX_BYTES bytes; the cut
//   byte is flagged with out_len_err and the next byte starts a new frame.
//
// Parameters:
//   MAX_BYTES   maximum bytes per frame (1..255)
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   in_valid     in   input byte pair valid
//   in_ready     out  byte pair accepted this cycle (when in_valid)
//   in_a   [7:0] in   minuend byte
//   in_b   [7:0] in   subtrahend byte
//   in_last      in   final (most-significant) byte of the frame
//   out_valid    out  result byte valid
//   out_ready    in   downstream takes the result byte
//   out_diff [7:0] out difference byte
//   out_last     out  final byte of the frame
//   out_borrow   out  unsigned borrow of the frame (with out_last, else 0)
//   out_ovf      out  signed overflow of the frame (with out_last, else 0)
//   out_len_err  out  frame was cut at MAX_BYTES (with out_last)
//   out_zero     out  whole-frame difference was zero (with out_last);
//                     present only when SUB8B_ZERO_FLAG_EN is defined
//
// Build option: define SUB8B_ZERO_FLAG_EN to add the out_zero flag.
//
// FSM states:
//   state   | meaning
//   S_FIRST | next accepted byte is the LSB of a new frame (carry forced 1)
//   S_BODY  | inside a frame; next byte uses the stored carry
module sub8b_serial
  import alu_pkg::*;
#(
  parameter int MAX_BYTES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_a,
  input  logic [BYTE_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_diff,
  output logic              out_last,
  output logic              out_borrow,
  output logic              out_ovf,
  output logic              out_len_err
`ifdef SUB8B_ZERO_FLAG_EN
  ,
  output logic              out_zero
`endif
);

  localparam int              CNT_W    = 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BYTES - 1);

  state_t             state_q;
  state_t             state_d;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               force_last;
  logic               frame_end;
  logic               cin;
  logic [BYTE_W-1:0]  b_inv;
  logic [BYTE_W-1:0]  diff;
  logic               cout;

  // The output register can take a new byte when it is empty or being
  // drained in the same cycle; nothing is taken while in reset.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Byte index MAX_BYTES-1 closes the frame whether or not in_last is set.
  assign force_last = (cnt_q == LAST_IDX);
  assign frame_end  = in_last || force_last;

  assign b_inv = ~in_b;

  sub8b_slice u_slice (
    .a    (in_a),
    .b    (b_inv),
    .cin  (cin),
    .sum  (diff),
    .cout (cout)
  );

  always_comb begin
    state_d = state_q;
    cin     = carry_q;
    case (state_q)
      S_FIRST: begin
        cin = 1'b1;
        if (accept) state_d = frame_end ? S_FIRST : S_BODY;
      end
      S_BODY: begin
        if (accept) state_d = frame_end ? S_FIRST : S_BODY;
      end
      default: begin
        cin     = 1'b1;
        state_d = S_FIRST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FIRST;
      carry_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        carry_q <= frame_end ? 1'b1 : cout;
        cnt_q   <= frame_end ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  // One-entry output register: loads on accept, empties when drained with no
  // replacement, and otherwise holds every field unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_diff    <= '0;
      out_last    <= 1'b0;
      out_borrow  <= 1'b0;
      out_ovf     <= 1'b0;
      out_len_err <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_diff    <= diff;
      out_last    <= frame_end;
      out_borrow  <= frame_end & ~cout;
      out_ovf     <= frame_end &
                     sub_ovf(in_a[BYTE_W-1], in_b[BYTE_W-1], diff[BYTE_W-1]);
      out_len_err <= force_last & ~in_last;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

`ifdef SUB8B_ZERO_FLAG_EN
  logic zero_run_q;
  logic zero_so_far;

  // A new frame starts with "all zero so far" regardless of history.
  assign zero_so_far = ((state_q == S_FIRST) || zero_run_q) && (diff == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_run_q <= 1'b1;
      out_zero   <= 1'b0;
    end else if (accept) begin
      zero_run_q <= frame_end ? 1'b1 : zero_so_far;
      out_zero   <= frame_end & zero_so_far;
    end
  end
`endif

endmodule

// File: tb/tb_sub8b_serial.sv
module tb_sub8b_serial;

  localparam int MAXB = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_diff;
  logic       out_last;
  logic       out_borrow;
  logic       out_ovf;
  logic       out_len_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       br;
    logic       ov;
    logic       le;
  } exp_t;

  sub8b_serial #(.MAX_BYTES(MAXB)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_diff    (out_diff),
    .out_last    (out_last),
    .out_borrow  (out_borrow),
    .out_ovf     (out_ovf),
    .out_len_err (out_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  // Presents one byte pair and waits (bounded) for the handshake; returns
  // 1 time unit after the accepting clock edge with in_valid dropped.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic l);
    int n;
    in_a = a; in_b = b; in_last = l; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL handshake_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = {out_valid, out_diff, out_last, out_borrow, out_ovf, out_len_err};
    checks++;
    if (obs !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0000", obs);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_single();
    logic [12:0] obs;
    out_ready = 1'b1;
    drive(8'h05, 8'h03, 1'b1);
    obs = {out_valid, out_diff, out_last, out_borrow, out_ovf, out_len_err};
    checks++;
    if (obs !== {1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_05_03: got %h required %h", obs,
               {1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_two_byte();
    logic [12:0] obs;
    out_ready = 1'b1;
    drive(8'h00, 8'h01, 1'b0);
    obs = {out_valid, out_diff, out_last, out_borrow, out_ovf, out_len_err};
    checks++;
    if (obs !== {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL two_byte_lo: got %h required %h", obs,
               {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    drive(8'h01, 8'h00, 1'b1);
    obs = {out_valid, out_diff, out_last, out_borrow, out_ovf, out_len_err};
    checks++;
    if (obs !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL two_byte_hi: got %h required %h", obs,
               {1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_ovf_borrow();
    logic [12:0] obs;
    out_ready = 1'b1;
    drive(8'h80, 8'h01, 1'b1);
    obs = {out_valid, out_diff, out_last, out_borrow, out_ovf, out_len_err};
    checks++;
    if (obs !== {1'b1, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_80_01: got %h required %h", obs,
               {1'b1, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    drive(8'h00, 8'h01, 1'b1);
    obs = {out_valid, out_diff, out_last, out_borrow, out_ovf, out_len_err};
    checks++;
    if (obs !== {1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL borrow_00_01: got %h required %h", obs,
               {1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(8'h12, 8'h34, 1'b1);
    checks++;
    if ({out_valid, out_diff, out_borrow} !== {1'b1, 8'hDE, 1'b1}) begin
      errors++;
      $display("FAIL stall_load: got %b %h %b required 1 de 1",
               out_valid, out_diff, out_borrow);
    end
    in_a = 8'h05; in_b = 8'h03; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_diff} !== {1'b0, 1'b1, 8'hDE}) begin
        errors++;
        $display("FAIL stall_hold_%0d: in_ready=%b out_valid=%b out_diff=%h required 0 1 de",
                 k, in_ready, out_valid, out_diff);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_diff} !== {1'b1, 8'h02}) begin
      errors++;
      $display("FAIL stall_release_1: got %b %h required 1 02", out_valid, out_diff);
    end
    in_a = 8'h10; in_b = 8'h01;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_diff} !== {1'b1, 8'h0F}) begin
      errors++;
      $display("FAIL stall_release_2: got %b %h required 1 0f", out_valid, out_diff);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_len_err();
    logic [12:0] obs;
    out_ready = 1'b1;
    drive(8'h10, 8'h01, 1'b0);
    drive(8'h10, 8'h01, 1'b0);
    drive(8'h10, 8'h01, 1'b0);
    obs = {out_valid, out_diff, out_last, out_borrow, out_ovf, out_len_err};
    checks++;
    if (obs !== {1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL len_byte3: got %h required %h", obs,
               {1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    drive(8'h00, 8'h01, 1'b0);
    obs = {out_valid, out_diff, out_last, out_borrow, out_ovf, out_len_err};
    checks++;
    if (obs !== {1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL len_byte4_cut: got %h required %h", obs,
               {1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1});
    end
    drive(8'h05, 8'h03, 1'b1);
    obs = {out_valid, out_diff, out_last, out_borrow, out_ovf, out_len_err};
    checks++;
    if (obs !== {1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL len_byte5_new_frame: got %h required %h", obs,
               {1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] obs;
    out_ready = 1'b1;
    drive(8'h00, 8'h01, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_in_ready: got %b required 0", in_ready);
    end
    @(posedge clk); #1;
    obs = {out_valid, out_diff, out_last, out_borrow, out_ovf, out_len_err};
    checks++;
    if (obs !== 13'h0) begin
      errors++;
      $display("FAIL mid_reset_clear: got %h required 0000", obs);
    end
    rst = 1'b0;
    drive(8'h05, 8'h03, 1'b1);
    obs = {out_valid, out_diff, out_last, out_borrow, out_ovf, out_len_err};
    checks++;
    if (obs !== {1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_new_frame: got %h required %h", obs,
               {1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0});
    end
  endtask

  function automatic logic [7:0] rnd_byte();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Random frames (some longer than MAXB, so they get cut) with random input
  // gaps and random output back-pressure. Expected bytes come from treating
  // each frame as whole integers A and B and doing A - B arithmetically.
  task automatic test_random();
    logic [7:0] sa[$];
    logic [7:0] sb[$];
    logic       sl[$];
    exp_t       expq[$];
    logic [7:0] fa[$];
    logic [7:0] fb[$];
    int         total;

    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        sa.push_back(rnd_byte());
        sb.push_back(rnd_byte());
        sl.push_back(i == len - 1);
      end
    end

    for (int i = 0; i < sa.size(); i++) begin
      fa.push_back(sa[i]);
      fb.push_back(sb[i]);
      if (sl[i] || fa.size() == MAXB) begin
        longint A, B, M, D, SA, SB, T;
        logic   brw, ovf;
        int     n;
        n = fa.size();
        A = 0; B = 0;
        for (int k = 0; k < n; k++) begin
          A = A | (longint'(fa[k]) << (8 * k));
          B = B | (longint'(fb[k]) << (8 * k));
        end
        M   = longint'(1) << (8 * n);
        D   = (A - B + M) % M;
        brw = (A < B);
        SA  = (A >= M / 2) ? A - M : A;
        SB  = (B >= M / 2) ? B - M : B;
        T   = SA - SB;
        ovf = (T < -(M / 2)) || (T >= M / 2);
        for (int k = 0; k < n; k++) begin
          exp_t e;
          e.d  = 8'((D >> (8 * k)) & 255);
          e.l  = (k == n - 1);
          e.br = (k == n - 1) && brw;
          e.ov = (k == n - 1) && ovf;
          e.le = (k == n - 1) && !sl[i];
          expq.push_back(e);
        end
        fa.delete();
        fb.delete();
      end
    end
    total = expq.size();

    fork
      begin : producer
        bit stuck;
        stuck = 1'b0;
        for (int i = 0; i < sa.size() && !stuck; i++) begin
          int n;
          while ($urandom_range(0, 4) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          in_a = sa[i]; in_b = sb[i]; in_last = sl[i]; in_valid = 1'b1;
          n = 0;
          @(negedge clk);
          while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
          end
          if (!in_ready) begin
            checks++; errors++;
            $display("FAIL rand_in_timeout: byte %0d in_ready=%b required 1", i, in_ready);
            stuck = 1'b1;
          end
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int got, cyc;
        got = 0; cyc = 0;
        while (got < total && cyc < 20000) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (out_valid && out_ready) begin
            exp_t e, o;
            o = {out_diff, out_last, out_borrow, out_ovf, out_len_err};
            checks++;
            if (expq.size() == 0) begin
              errors++;
              $display("FAIL rand_extra_output: got %h required none", o);
            end else begin
              e = expq.pop_front();
              if (o !== e) begin
                errors++;
                $display("FAIL rand_byte_%0d: got diff=%h last=%b brw=%b ovf=%b lerr=%b required diff=%h last=%b brw=%b ovf=%b lerr=%b",
                         got, o.d, o.l, o.br, o.ov, o.le, e.d, e.l, e.br, e.ov, e.le);
              end
            end
            got++;
          end
          cyc++;
        end
        checks++;
        if (got != total) begin
          errors++;
          $display("FAIL rand_out_timeout: received %0d bytes required %0d", got, total);
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_two_byte();
    test_ovf_borrow();
    test_stall();
    test_len_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
